// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit-drain and receive blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: transmit-drain state encoding, default bit period, packet depth
// and character width.
package uart_pkg;

  // 50 MHz core clock at 115200 baud.
  localparam int DEF_CLKS_PER_BIT = 434;
  // Bytes per packet; tracks the transmit buffer depth.
  localparam int DEF_WORDS        = 4;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT,
    LOAD,
    DRAIN
  } tx_state_e;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read-side link between the transmit buffer and the drain transmitter.
// Latency: buf_data is combinational from the buffer read pointer; buf_rd advances it on the next edge.
// Backpressure: none; the buffer must present a valid word whenever buf_full is high.
//
// Signals:
//   buf_full  buffer -> drain  buffer holds a complete packet of unread bytes
//   buf_data  buffer -> drain  word at the current read pointer
//   buf_rd    drain -> buffer  one-cycle pulse, advance read pointer
// Modports: master = drain (reader), slave = buffer.
interface uart_tx_drain_if;
  import uart_pkg::*;

  logic                 buf_full;
  logic [DATA_BITS-1:0] buf_data;
  logic                 buf_rd;

  modport master (
    input  buf_full,
    input  buf_data,
    output buf_rd
  );

  modport slave (
    output buf_full,
    output buf_data,
    input  buf_rd
  );

endinterface

// File: rtl/uart_tx_drain.sv
// UART 8N1 transmitter that empties a full WORDS-deep transmit buffer, LSB first.
// Latency: first start bit one cycle after full is seen; done_tick at WORDS*(10*CLKS_PER_BIT+2)-1.
// Backpressure: none; once started a packet runs to completion, full changes ignored mid-packet.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high
//   bif        buffer read side (master modport): buf_full, buf_data in; buf_rd out
//   tx         serial line, idles high (registered)
//   busy       high in every state except IDLE (decoded from state)
//   done_tick  one-cycle pulse as the last byte of a packet completes (registered)
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int WORDS        = DEF_WORDS
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_drain_if.master bif,
  output logic            tx,
  output logic            busy,
  output logic            done_tick
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = $clog2(WORDS) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(WORDS - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e            state_q,    state_d;
  logic [BAUD_W-1:0]    baud_q,     baud_d;
  logic [2:0]           bit_cnt_q,  bit_cnt_d;
  logic [BYTE_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 tx_q,       tx_d;
  logic                 buf_rd_q,   buf_rd_d;
  logic                 done_q,     done_d;

  logic bit_end;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    buf_rd_d   = 1'b0;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    bit_end = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        if (bif.buf_full) begin
          shift_d    = bif.buf_data;
          byte_cnt_d = '0;
          baud_d     = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = NEXT;
          // Outputs are registered, so the NEXT-cycle pulses are raised on
          // the edge that enters NEXT.
          buf_rd_d = 1'b1;
          done_d   = (byte_cnt_q == BYTE_LAST);
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      NEXT: begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        state_d    = (byte_cnt_q == BYTE_LAST) ? DRAIN : LOAD;
      end

      LOAD: begin
        // buf_rd was high during NEXT, so buf_data now shows the next byte.
        shift_d = bif.buf_data;
        baud_d  = '0;
        state_d = START;
      end

      DRAIN: begin
        // Hold off until the buffer drops its flag so a stale full cannot
        // launch a second packet.
        if (!bif.buf_full) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level follows the state being entered so tx lines up with state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      buf_rd_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      buf_rd_q   <= buf_rd_d;
      done_q     <= done_d;
    end
  end

  assign bif.buf_rd = buf_rd_q;
  assign tx         = tx_q;
  assign done_tick  = done_q;
  assign busy       = (state_q != IDLE);

endmodule
